// File: rtl/epcs_read_sequencer_if.sv
// Bundle of request, byte-stream and SPI-master register-port signals for the EPCS read sequencer.
// The master modport is the sequencer side; slave is the SPI master, flash stream sink and requester.
interface epcs_read_sequencer_if;
  // Request
  logic        start;
  logic [23:0] start_addr;
  logic [15:0] byte_count;
  logic        busy;
  logic        done;

  // Received byte stream
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  // SPI master register port
  logic        spi_select;
  logic [2:0]  spi_mem_addr;
  logic [15:0] spi_data_from_cpu;
  logic        spi_write_n;
  logic        spi_read_n;
  logic [15:0] spi_data_to_cpu;
  logic        spi_dataavailable;

  modport master (
    input  start, start_addr, byte_count, out_ready, spi_data_to_cpu, spi_dataavailable,
    output busy, done, out_data, out_valid,
    output spi_select, spi_mem_addr, spi_data_from_cpu, spi_write_n, spi_read_n
  );

  modport slave (
    output start, start_addr, byte_count, out_ready, spi_data_to_cpu, spi_dataavailable,
    input  busy, done, out_data, out_valid,
    input  spi_select, spi_mem_addr, spi_data_from_cpu, spi_write_n, spi_read_n
  );
endinterface

// File: rtl/epcs_read_sequencer.sv
// Drives an SPI master register port to issue an EPCS flash READ (opcode + 24-bit address)
// and streams the returned bytes out through a valid/ready port, one SPI access at a time.
module epcs_read_sequencer #(
  parameter logic [7:0] READ_CMD = 8'h03,
  parameter logic [7:0] DUMMY_TX = 8'h00
) (
  input  logic                         clk,
  input  logic                         reset,
  epcs_read_sequencer_if.master        bus
);

  localparam logic [2:0]  REG_RXDATA  = 3'd0;
  localparam logic [2:0]  REG_TXDATA  = 3'd1;
  localparam logic [2:0]  REG_STATUS  = 3'd2;
  localparam logic [2:0]  REG_CONTROL = 3'd3;
  localparam logic [15:0] CTRL_SSO    = 16'h0400;
  localparam logic [2:0]  HDR_BYTES   = 3'd4;

  typedef enum logic [3:0] {
    IDLE, CLR, SSON, TX, WRX, RD, OUT, SSOFF, DONE
  } state_t;

  state_t      r_state;
  logic [1:0]  r_phase;
  logic [2:0]  r_hdr_cnt;
  logic [15:0] r_remaining;
  logic [23:0] r_addr;
  logic [7:0]  r_rx;

  state_t      w_state_next;
  logic [1:0]  w_phase_next;
  logic [2:0]  w_hdr_next;
  logic [15:0] w_rem_next;
  logic [23:0] w_addr_next;
  logic [7:0]  w_rx_next;

  logic        w_access;
  logic        w_acc_last;
  logic        w_strobe;
  logic [7:0]  w_tx_byte;
  logic [2:0]  w_reg_addr;
  logic [15:0] w_reg_data;
  logic        w_unused_rx_hi;

  // Access states: phases 0 and 1 hold the strobe, phase 2 is the mandatory idle gap.
  assign w_access   = (r_state == CLR) || (r_state == SSON) || (r_state == TX) ||
                      (r_state == RD)  || (r_state == SSOFF);
  assign w_acc_last = (r_phase == 2'd2);
  assign w_strobe   = w_access && !w_acc_last;

  always_comb begin
    unique case (r_hdr_cnt)
      3'd4:    w_tx_byte = READ_CMD;
      3'd3:    w_tx_byte = r_addr[23:16];
      3'd2:    w_tx_byte = r_addr[15:8];
      3'd1:    w_tx_byte = r_addr[7:0];
      default: w_tx_byte = DUMMY_TX;
    endcase
  end

  always_comb begin
    w_reg_addr = REG_RXDATA;
    w_reg_data = 16'h0000;
    unique case (r_state)
      CLR:     w_reg_addr = REG_STATUS;
      SSON:    begin w_reg_addr = REG_CONTROL; w_reg_data = CTRL_SSO; end
      TX:      begin w_reg_addr = REG_TXDATA;  w_reg_data = {8'h00, w_tx_byte}; end
      SSOFF:   w_reg_addr = REG_CONTROL;
      default: w_reg_addr = REG_RXDATA;
    endcase
  end

  // Address and data are forced to zero outside the strobe so the port rests at its reset values.
  assign bus.spi_select        = w_strobe;
  assign bus.spi_write_n       = !(w_strobe && (r_state != RD));
  assign bus.spi_read_n        = !(w_strobe && (r_state == RD));
  assign bus.spi_mem_addr      = w_strobe ? w_reg_addr : 3'd0;
  assign bus.spi_data_from_cpu = w_strobe ? w_reg_data : 16'h0000;

  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = (r_state == DONE);
  assign bus.out_valid = (r_state == OUT);
  assign bus.out_data  = r_rx;

  assign w_unused_rx_hi = ^bus.spi_data_to_cpu[15:8];

  // NOTE: every next-state signal gets a default before the case so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_phase_next = w_access ? (w_acc_last ? 2'd0 : r_phase + 2'd1) : 2'd0;
    w_hdr_next   = r_hdr_cnt;
    w_rem_next   = r_remaining;
    w_addr_next  = r_addr;
    w_rx_next    = r_rx;

    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_next = CLR;
          w_addr_next  = bus.start_addr;
          w_rem_next   = bus.byte_count;
          w_hdr_next   = HDR_BYTES;
        end
      end
      CLR:   if (w_acc_last) w_state_next = SSON;
      SSON:  if (w_acc_last) w_state_next = TX;
      TX:    if (w_acc_last) w_state_next = WRX;
      WRX:   if (bus.spi_dataavailable) w_state_next = RD;
      RD: begin
        // Read data is registered by the master; take it at the end of the second strobe cycle.
        if (r_phase == 2'd1) w_rx_next = bus.spi_data_to_cpu[7:0];
        if (w_acc_last) begin
          if (r_hdr_cnt != 3'd0) begin
            w_hdr_next   = r_hdr_cnt - 3'd1;
            w_state_next = ((r_hdr_cnt == 3'd1) && (r_remaining == 16'd0)) ? SSOFF : TX;
          end else begin
            w_state_next = OUT;
          end
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          w_rem_next   = (r_remaining != 16'd0) ? r_remaining - 16'd1 : 16'd0;
          w_state_next = (r_remaining > 16'd1) ? TX : SSOFF;
        end
      end
      SSOFF: if (w_acc_last) w_state_next = DONE;
      DONE:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_phase     <= 2'd0;
      r_hdr_cnt   <= 3'd0;
      r_remaining <= 16'd0;
      r_addr      <= 24'd0;
      r_rx        <= 8'd0;
    end else begin
      r_state     <= w_state_next;
      r_phase     <= w_phase_next;
      r_hdr_cnt   <= w_hdr_next;
      r_remaining <= w_rem_next;
      r_addr      <= w_addr_next;
      r_rx        <= w_rx_next;
    end
  end

endmodule

// File: tb/tb_epcs_read_sequencer.sv
// Directed bench for epcs_read_sequencer: SPI master/flash model, register-port access monitor,
// byte-stream scoreboard with hand-computed expected write logs and data bytes.
module tb_epcs_read_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  epcs_read_sequencer_if bus ();

  epcs_read_sequencer #(.READ_CMD(8'h03), .DUMMY_TX(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Flash contents returned in the data phase, in order.
  logic [7:0] flash [0:7];

  // Model and monitor state
  logic [18:0] wlog [$];
  logic [7:0]  outq [$];
  int          done_cnt, overrun, valid_cnt, valid_drop, data_change;
  int          run_len, tx_k, lat;
  logic [7:0]  pend;
  logic [2:0]  run_addr;
  logic [15:0] run_data;
  logic        run_wn, run_rn, run_stable;
  logic        prev_valid, prev_ready;
  logic [7:0]  prev_data;

  always @(negedge clk) begin
    if (reset) begin
      run_len = 0; lat = 0; tx_k = 0;
      bus.spi_dataavailable = 1'b0;
      prev_valid = 1'b0; prev_ready = 1'b0;
    end else begin
      if (bus.spi_select) begin
        if (run_len == 0) begin
          run_addr = bus.spi_mem_addr; run_data = bus.spi_data_from_cpu;
          run_wn = bus.spi_write_n; run_rn = bus.spi_read_n; run_stable = 1'b1;
        end else if ({run_addr, run_data, run_wn, run_rn} !==
                     {bus.spi_mem_addr, bus.spi_data_from_cpu, bus.spi_write_n, bus.spi_read_n}) begin
          run_stable = 1'b0;
        end
        run_len++;
        if (run_len == 2) begin
          if (!run_wn) begin
            wlog.push_back({run_addr, run_data});
            if (run_addr == 3'd3 && run_data == 16'h0400) tx_k = 0;
            if (run_addr == 3'd1) begin
              if (bus.spi_dataavailable || lat != 0) overrun++;
              if (tx_k < 4) pend = 8'hEE;
              else pend = flash[tx_k-4];
              tx_k++;
              lat = 4;
            end
          end
          if (!run_rn) bus.spi_dataavailable = 1'b0;
        end
      end else if (run_len != 0) begin
        check("acc_len", run_len, 2);
        check("acc_stable_one_strobe", {run_stable, run_wn ^ run_rn}, 2'b11);
        run_len = 0;
      end

      if (lat != 0) begin
        lat--;
        if (lat == 0) begin
          bus.spi_data_to_cpu   = {8'h00, pend};
          bus.spi_dataavailable = 1'b1;
        end
      end

      if (prev_valid && !prev_ready && !bus.out_valid) valid_drop++;
      if (prev_valid && !prev_ready && bus.out_data !== prev_data) data_change++;
      if (bus.out_valid) valid_cnt++;
      if (bus.out_valid && bus.out_ready) outq.push_back(bus.out_data);
      if (bus.done) done_cnt++;
      prev_valid = bus.out_valid; prev_ready = bus.out_ready; prev_data = bus.out_data;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_start(input logic [23:0] a, input logic [15:0] n);
    bus.start_addr = a; bus.byte_count = n; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic clear_logs();
    wlog.delete(); outq.delete();
    done_cnt = 0; overrun = 0; valid_cnt = 0; valid_drop = 0; data_change = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    check(tag, {bus.busy, bus.done, bus.out_valid, bus.out_data, bus.spi_select, bus.spi_write_n,
                bus.spi_read_n, bus.spi_mem_addr, bus.spi_data_from_cpu},
               {1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 3'd0, 16'h0000});
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clk);
      seen = bus.done;
    end
    check({tag, "_done_seen"}, seen, 1'b1);
    tick();
    check({tag, "_idle_after_done"}, bus.busy, 1'b0);
    tick();
  endtask

  task automatic wait_out(input int n, input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clk);
      seen = (outq.size() >= n);
    end
    check({tag, "_out_reached"}, seen, 1'b1);
  endtask

  // Expected register writes: STATUS clear, SSO on, header, dummies, SSO off.
  task automatic check_log(input string tag, input logic [23:0] a, input int n);
    logic [18:0] exp [$];
    exp.push_back({3'd2, 16'h0000});
    exp.push_back({3'd3, 16'h0400});
    exp.push_back({3'd1, 16'h0003});
    exp.push_back({3'd1, 8'h00, a[23:16]});
    exp.push_back({3'd1, 8'h00, a[15:8]});
    exp.push_back({3'd1, 8'h00, a[7:0]});
    for (int i = 0; i < n; i++) exp.push_back({3'd1, 16'h0000});
    exp.push_back({3'd3, 16'h0000});
    check({tag, "_log_len"}, wlog.size(), exp.size());
    if (wlog.size() > 0) check({tag, "_log_clr_addr"}, wlog[0][18:16], 3'd2);
    for (int i = 1; i < exp.size() && i < wlog.size(); i++)
      check($sformatf("%s_log%0d", tag, i), wlog[i], exp[i]);
  endtask

  task automatic check_out(input string tag, input int n);
    check({tag, "_out_len"}, outq.size(), n);
    for (int i = 0; i < n && i < outq.size(); i++)
      check($sformatf("%s_out%0d", tag, i), outq[i], flash[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         held, stable;
    int         wl;
    logic [7:0] d;

    flash[0] = 8'hA5; flash[1] = 8'h5A; flash[2] = 8'hC3; flash[3] = 8'h99;
    flash[4] = 8'h11; flash[5] = 8'h22; flash[6] = 8'h33; flash[7] = 8'h44;
    bus.start = 1'b0; bus.start_addr = '0; bus.byte_count = '0; bus.out_ready = 1'b0;
    bus.spi_data_to_cpu = 16'h0000; bus.spi_dataavailable = 1'b0;
    clear_logs();
    reset = 1'b1;
    repeat (3) tick();
    check_reset_vals("reset_state");
    reset = 1'b0;
    tick();

    // Three-byte read, with a second start pulsed mid-transfer that must be ignored
    clear_logs();
    bus.out_ready = 1'b1;
    run_start(24'h123456, 16'd3);
    check("a_busy_after_start", bus.busy, 1'b1);
    wait_out(1, "a");
    run_start(24'hABCDEF, 16'd9);
    wait_done("a");
    check_log("a", 24'h123456, 3);
    check_out("a", 3);
    check("a_done_pulses", done_cnt, 1);
    check("a_overrun", overrun, 0);

    // Zero-length read: header only, no stream output
    clear_logs();
    run_start(24'h00ABCD, 16'd0);
    wait_done("b");
    check_log("b", 24'h00ABCD, 0);
    check("b_valid_cycles", valid_cnt, 0);
    check("b_done_pulses", done_cnt, 1);

    // Backpressure on the first byte for 20 cycles
    clear_logs();
    bus.out_ready = 1'b0;
    run_start(24'h123456, 16'd2);
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 3000 && !seen; k++) begin
        @(negedge clk);
        seen = bus.out_valid;
      end
      check("c_valid_reached", seen, 1'b1);
    end
    d = bus.out_data; wl = wlog.size(); held = 1'b1; stable = 1'b1;
    check("c_first_byte", d, 8'hA5);
    repeat (20) begin
      @(negedge clk);
      if (!bus.out_valid) held = 1'b0;
      if (bus.out_data !== d) stable = 1'b0;
    end
    check("c_valid_held", held, 1'b1);
    check("c_data_stable", stable, 1'b1);
    check("c_no_write_while_stalled", wlog.size(), wl);
    tick();
    bus.out_ready = 1'b1;
    wait_done("c");
    check_log("c", 24'h123456, 2);
    check_out("c", 2);
    check("c_valid_drop", valid_drop, 0);
    check("c_data_change", data_change, 0);

    // Reset during data byte 2, then a clean rerun
    clear_logs();
    run_start(24'h123456, 16'd3);
    wait_out(1, "d");
    repeat (4) tick();
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("d_reset_abort");
    repeat (2) tick();
    reset = 1'b0;
    tick();
    clear_logs();
    run_start(24'h123456, 16'd3);
    wait_done("d");
    check_log("d", 24'h123456, 3);
    check_out("d", 3);
    check("d_done_pulses", done_cnt, 1);
    check("d_overrun", overrun, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/epcs_read_sequencer.md
EPCS_READ_SEQUENCER -- requirements
Module: epcs_read_sequencer

Interface
REQ-001 Parameter: READ_CMD, 8'h03, flash read opcode sent as the first SPI byte.
REQ-002 Parameter: DUMMY_TX, 8'h00, byte shifted out during the data phase.
REQ-003 clk  in  1  single system clock; all flops on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  one-cycle request; sampled only in IDLE.
REQ-006 start_addr  in  24  flash byte address, captured on accepted start.
REQ-007 byte_count  in  16  number of data bytes to read, captured on accepted start.
REQ-008 busy  out  1  high from the cycle after an accepted start until DONE is left.
REQ-009 done  out  1  one-cycle pulse when the sequence completes.
REQ-010 out_data  out  8  received flash byte.
REQ-011 out_valid  out  1  out_data is valid; held until out_ready.
REQ-012 out_ready  in  1  downstream accept; transfer happens when out_valid and out_ready are both high.
REQ-013 spi_select  out  1  chip select to the SPI master register port.
REQ-014 spi_mem_addr  out  3  SPI master register address.
REQ-015 spi_data_from_cpu  out  16  write data to the SPI master.
REQ-016 spi_write_n / spi_read_n  out  1 each  active-low strobes.
REQ-017 spi_data_to_cpu  in  16  registered read data from the SPI master.
REQ-018 spi_dataavailable  in  1  SPI master RRDY.

Function
REQ-019 Every SPI master access SHALL last exactly 2 cycles: spi_select=1 and the strobe low for both cycles; address and data held stable for both; all SPI outputs idle (select 0, strobes 1) for at least 1 cycle between accesses.
REQ-020 For a read access, spi_data_to_cpu SHALL be captured at the end of the 2nd cycle.
REQ-021 FSM states: IDLE, CLR, SSON, TX, WRX, RD, OUT, SSOFF, DONE.
REQ-022 IDLE→CLR on start: latch start_addr and byte_count, and load the header counter with 4 bytes (opcode plus 3 address bytes).
REQ-023 CLR: write addr 2 (any data) to clear the status register, then go to SSON.
REQ-024 SSON: write addr 3 with data 16'h0400 (SSO=1) so SS_n stays low across bytes, then go to TX.
REQ-025 TX: write addr 1; the data is, in header order, READ_CMD, addr[23:16], addr[15:8], addr[7:0]; once the header is exhausted, the data is DUMMY_TX. Upper 8 bits are 0. Then go to WRX.
REQ-026 WRX: wait until spi_dataavailable=1, with no timeout, then go to RD.
REQ-027 RD: read addr 0; it clears RRDY in the master. In the header phase, discard the byte, decrement the header counter, and go to TX, or to SSOFF if the header is done and the remaining count is 0. In the data phase, go to OUT.
REQ-028 OUT: out_valid=1 with out_data = captured low byte. On handshake, decrement the remaining count (16-bit, no wrap below 0); go to TX if the count is nonzero, else to SSOFF.
REQ-029 SSOFF: write addr 3 with data 16'h0000 to release SS_n, then go to DONE.
REQ-030 DONE: pulse done for 1 cycle, then go to IDLE; busy deasserts in the same cycle as the return to IDLE.
REQ-031 byte_count=0: the header is still sent, no out_valid occurs, and done follows SSOFF.
REQ-032 start while busy SHALL be ignored, with no relatch.
REQ-033 out_valid SHALL never drop without a handshake; out_data SHALL stay stable while out_valid=1.
REQ-034 Throughput: at most one SPI access is in flight; there is no pipelining of TX ahead of RX, so ROE never sets.

Reset
REQ-035 On reset: state=IDLE, busy=0, done=0, out_valid=0, out_data=0, spi_select=0, spi_write_n=1, spi_read_n=1, spi_mem_addr=0, spi_data_from_cpu=0, all counters 0.
REQ-036 Reset mid-sequence SHALL abort immediately to the reset values; releasing SS_n in the master is then the master's own reset responsibility.

Verification
REQ-037 Run start_addr=24'h123456, byte_count=3 against a master model with flash returning A5,5A,C3 → SPI writes seen in order: addr2; addr3=0400; addr1=03,12,34,56,00,00,00; addr3=0000; out bytes A5,5A,C3; one done pulse.
REQ-038 Run byte_count=0 → 4 header bytes, no out_valid, SSOFF write, then done.
REQ-039 Hold out_ready=0 for 20 cycles on the first byte → out_valid held, out_data stable, no further addr1 write until the handshake.
REQ-040 Pulse start again at mid-transfer → no effect; the write sequence is identical to REQ-037.
REQ-041 Assert reset during data byte 2 → all outputs at reset values next cycle; a fresh start afterwards runs a complete sequence from CLR.
REQ-042 Check every SPI access → exactly 2 cycles of select with stable addr/data, and idle gaps ≥1 cycle.
